ps2_kbd_intr_ctrl: RTL and testbench

PS/2 keyboard receiver and scan-code FIFO that feeds the single-cycle interrupt CPU. It sits in the I/O space at 0xa000_0000-0xbfff_ffff. It deserialises PS/2 frames and buffers valid scan codes. It raises the level keyboard interrupt (CPU intr1) while codes are pending, and pops one code per CPU I/O read (io_rdn low).

---
 rtl/ps2_kbd_intr_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ps2_kbd_intr_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_intr_ctrl.sv
// ps2_kbd_intr_ctrl
// PS/2 keyboard receiver with a scan-code FIFO for the single-cycle
// interrupt CPU, mapped into I/O space 0xa000_0000-0xbfff_ffff.
// Frames arriving on the PS/2 pads are deserialised and checked for start,
// parity and stop errors. Good scan codes are queued. A level interrupt
// stays asserted while codes are waiting. Each CPU I/O read removes one code.
//
// Ports:
//   clock     - system clock; all logic runs on the rising edge
//   reset     - synchronous, active-high reset
//   ps2_clk   - raw PS/2 clock from the pad (asynchronous)
//   ps2_data  - raw PS/2 data from the pad (asynchronous)
//   io_rdn    - CPU I/O read strobe, active low, one clock per lw
//   data      - scan code at the FIFO head, 0x00 when the FIFO is empty
//   ready     - FIFO holds at least one code
//   intr      - keyboard interrupt request (CPU intr1), same as ready
//   overflow  - sticky flag: a good code was dropped because the FIFO was full
//   frame_err - one-cycle pulse on a start, parity, stop or timeout error
module ps2_kbd_intr_ctrl #(
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       io_rdn,
    output logic [7:0] data,
    output logic       ready,
    output logic       intr,
    output logic       overflow,
    output logic       frame_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    // The counter reaches TIMEOUT_CYCLES on the edge that follows this value.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    // Synchroniser and edge detector state
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;

    // Receiver state
    logic [0:0]    state;
    logic [3:0]    bit_cnt;
    logic [8:0]    shift_reg;
    logic [TW-1:0] tcnt;

    // FIFO state
    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;

    // Combinational helpers
    logic fall;
    logic din;
    logic frame_done;
    logic frame_good;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;

    // Two-flop synchronisers on both pads. The idle PS/2 bus is high, so the
    // synchronisers reset high to avoid a spurious falling edge after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    // Edge detection, frame completion and FIFO handshake decisions.
    // shift_reg holds data bits 1-8 in [7:0] and parity in [8] by the time
    // the stop bit arrives, so reduction XOR gives the odd-parity check.
    always_comb begin
        fall       = clk_prev & ~clk_sync[1];
        din        = data_sync[1];
        frame_done = (state == ST_RECV) && fall && (bit_cnt == 4'd10);
        frame_good = frame_done && (^shift_reg) && din;
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
        pop        = ~io_rdn && ~fifo_empty;
        // A pop in the same cycle frees the slot a full FIFO needs.
        push       = frame_good && (~fifo_full || pop);
    end

    // Frame receiver. The start bit moves IDLE to RECV with bit_cnt=1; each
    // later falling edge samples bit number bit_cnt. The edge with
    // bit_cnt=10 carries the stop bit and ends the frame either way.
    // The timeout counter only runs between edges inside a frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shift_reg <= 9'd0;
            tcnt      <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (state == ST_IDLE) begin
                tcnt <= '0;
                if (fall && !din) begin
                    state     <= ST_RECV;
                    bit_cnt   <= 4'd1;
                    shift_reg <= 9'd0;
                end
            end else begin
                if (fall) begin
                    tcnt <= '0;
                    if (bit_cnt == 4'd10) begin
                        state     <= ST_IDLE;
                        bit_cnt   <= 4'd0;
                        frame_err <= ~frame_good;
                    end else begin
                        shift_reg <= {din, shift_reg[8:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                    end
                end else if (tcnt == TIMEOUT_LAST) begin
                    state     <= ST_IDLE;
                    bit_cnt   <= 4'd0;
                    tcnt      <= '0;
                    frame_err <= 1'b1;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

    // FIFO pointers and the sticky overflow flag. A successful pop always
    // clears overflow; a good frame that finds the FIFO full with no pop
    // sets it and leaves the FIFO untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (pop) begin
                overflow <= 1'b0;
            end else if (frame_good && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage needs no reset; the head is masked while empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= shift_reg[7:0];
        end
    end

    assign data  = fifo_empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];
    assign ready = ~fifo_empty;
    assign intr  = ~fifo_empty;

endmodule

// File: tb/tb_ps2_kbd_intr_ctrl.sv
// tb_ps2_kbd_intr_ctrl
// Self-checking bench for ps2_kbd_intr_ctrl. A PS/2 host model drives frames
// on the pads; a queue-based keyboard buffer model predicts ready, intr,
// data, overflow and the number of frame_err pulses.
module tb_ps2_kbd_intr_ctrl;

    localparam int PERIOD  = 10;
    localparam int HALF    = 4;
    localparam int TIMEOUT = 100;
    localparam int DEPTH   = 8;

    logic       clock;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       io_rdn;
    logic [7:0] data;
    logic       ready;
    logic       intr;
    logic       overflow;
    logic       frame_err;

    // Reference model
    logic [7:0] model_q[$];
    bit         model_ovf;
    int         exp_err;

    int  vectors;
    int  miscompares;
    int  err_pulses;
    int  err_run;
    int  max_run;
    time last_fall_time;
    time err_time;

    ps2_kbd_intr_ctrl #(
        .FIFO_AW(3),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .io_rdn(io_rdn),
        .data(data),
        .ready(ready),
        .intr(intr),
        .overflow(overflow),
        .frame_err(frame_err)
    );

    // Free-running system clock
    initial begin
        clock = 1'b0;
        forever #(PERIOD / 2) clock = ~clock;
    end

    // Counts frame_err pulses and the longest run of consecutive high cycles
    always @(negedge clock) begin
        if (frame_err === 1'b1) begin
            err_run = err_run + 1;
            if (err_run == 1) begin
                err_pulses = err_pulses + 1;
                err_time   = $time;
            end
            if (err_run > max_run) max_run = err_run;
        end else begin
            err_run = 0;
        end
    end

    // Hard stop in case the design never lets the sequence proceed
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] exp_data;
        logic       exp_rdy;
        exp_rdy  = (model_q.size() != 0);
        exp_data = exp_rdy ? model_q[0] : 8'h00;
        checkValue({tag, "_ready"}, 16'(ready), 16'(exp_rdy));
        checkValue({tag, "_intr"}, 16'(intr), 16'(exp_rdy));
        checkValue({tag, "_data"}, 16'(data), 16'(exp_data));
        checkValue({tag, "_ovf"}, 16'(overflow), 16'(model_ovf));
        checkValue({tag, "_errcnt"}, 16'(err_pulses), 16'(exp_err));
        checkValue({tag, "_errlen"}, 16'(max_run), 16'((exp_err > 0) ? 1 : 0));
    endtask

    task automatic modelPush(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_err++;
        end else if (model_q.size() < DEPTH) begin
            model_q.push_back(b);
        end else begin
            model_ovf = 1'b1;
        end
    endtask

    task automatic modelPop();
        if (model_q.size() != 0) begin
            void'(model_q.pop_front());
            model_ovf = 1'b0;
        end
    endtask

    // Drives the first nbits of a PS/2 frame for byte b (start, 8 data bits
    // LSB first, odd parity, stop). mode 1 checks the push latency on the
    // final edge; mode 2 pulses io_rdn in the cycle the frame completes.
    task automatic applyStimulus(input logic [7:0] b, input bit bad_par,
                                 input int mode, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clock);
            ps2_clk        = 1'b0;
            last_fall_time = $time;
            if (i == 10 && mode == 1) begin
                @(posedge clock);
                @(posedge clock);
                #1;
                checkValue("lat_ready_early", 16'(ready), 16'd0);
                @(posedge clock);
                #1;
                checkValue("lat_ready", 16'(ready), 16'd1);
                checkValue("lat_intr", 16'(intr), 16'd1);
                checkValue("lat_data", 16'(data), 16'(b));
            end
            if (i == 10 && mode == 2) begin
                @(posedge clock);
                @(posedge clock);
                #1;
                io_rdn = 1'b0;
                @(posedge clock);
                #1;
                io_rdn = 1'b1;
            end
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        @(negedge clock);
        ps2_data = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic popOne();
        @(negedge clock);
        io_rdn = 1'b0;
        @(negedge clock);
        io_rdn = 1'b1;
        modelPop();
    endtask

    task automatic resetDut();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int         waited;
        int         delta;
        logic [7:0] b;
        bit         bad;

        vectors     = 0;
        miscompares = 0;
        err_pulses  = 0;
        err_run     = 0;
        max_run     = 0;
        exp_err     = 0;
        model_ovf   = 1'b0;
        reset       = 1'b1;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        io_rdn      = 1'b1;

        // Reset state
        resetDut();
        checkOutput("reset");
        checkValue("reset_ferr", 16'(frame_err), 16'd0);

        // Single good frame with exact latency, then one pop
        applyStimulus(8'h1C, 1'b0, 1, 11);
        modelPush(8'h1C, 1'b1);
        checkOutput("f1c");
        popOne();
        checkOutput("f1c_pop");

        // Pop while empty has no effect
        popOne();
        checkOutput("empty_pop");

        // Parity error, then a good frame
        applyStimulus(8'h1C, 1'b1, 0, 11);
        modelPush(8'h1C, 1'b0);
        checkOutput("bad_par");
        applyStimulus(8'hF0, 1'b0, 0, 11);
        modelPush(8'hF0, 1'b1);
        checkOutput("f0");
        popOne();
        checkOutput("f0_pop");

        // Nine frames into an eight-deep FIFO
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(8'(k), 1'b0, 0, 11);
            modelPush(8'(k), 1'b1);
        end
        checkOutput("ovf_fill");
        for (int k = 0; k < 8; k++) begin
            popOne();
            checkOutput("ovf_drain");
        end

        // Partial frame abandoned: timeout, then recovery
        applyStimulus(8'hA5, 1'b0, 0, 5);
        waited = 0;
        while (err_pulses == exp_err && waited < 3 * TIMEOUT) begin
            @(negedge clock);
            waited++;
        end
        checkValue("timeout_seen", 16'(err_pulses != exp_err), 16'd1);
        delta = int'((err_time - last_fall_time) / PERIOD);
        checkValue("timeout_window",
                   16'((delta >= TIMEOUT + 1) && (delta <= TIMEOUT + 5)), 16'd1);
        modelPush(8'hA5, 1'b0);
        repeat (4) @(negedge clock);
        checkOutput("timeout");
        applyStimulus(8'h5A, 1'b0, 0, 11);
        modelPush(8'h5A, 1'b1);
        checkOutput("f5a");
        popOne();

        // Full FIFO: completing frame and pop in the same cycle
        for (int k = 0; k < DEPTH; k++) begin
            b = 8'($urandom_range(0, 255));
            applyStimulus(b, 1'b0, 0, 11);
            modelPush(b, 1'b1);
        end
        checkOutput("full");
        applyStimulus(8'h77, 1'b0, 2, 11);
        modelPop();
        modelPush(8'h77, 1'b1);
        checkOutput("full_swap");
        for (int k = 0; k < DEPTH; k++) begin
            popOne();
            checkOutput("full_drain");
        end

        // Reset in the middle of a frame with codes queued
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom_range(0, 255));
            applyStimulus(b, 1'b0, 0, 11);
            modelPush(b, 1'b1);
        end
        checkOutput("pre_reset");
        applyStimulus(8'h3C, 1'b0, 0, 6);
        resetDut();
        model_q.delete();
        model_ovf = 1'b0;
        checkOutput("mid_reset");
        checkValue("mid_reset_ferr", 16'(frame_err), 16'd0);
        applyStimulus(8'h29, 1'b0, 0, 11);
        modelPush(8'h29, 1'b1);
        checkOutput("f29");
        popOne();
        checkOutput("f29_pop");

        // Randomised frames, errors and pops
        for (int k = 0; k < 24; k++) begin
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            applyStimulus(b, bad, 0, 11);
            modelPush(b, !bad);
            checkOutput("rand_rx");
            for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
                popOne();
                checkOutput("rand_pop");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
